// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - store-width codes (req_wr_strb) and load-type codes (req_rd_strb, funct3)
//   - responder FSM state type
//   - load_extend(): picks the addressed byte/half of a RAM word and extends it
package dmem_pkg;

  localparam logic [1:0] SW_BYTE = 2'b00;
  localparam logic [1:0] SW_HALF = 2'b01;
  localparam logic [1:0] SW_WORD = 2'b10;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Reserved load codes return 0; alignment is checked elsewhere.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  addr_lo,
                                              input logic [2:0]  ld_type);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*addr_lo +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_B:    r = {{24{b[7]}}, b};
      LD_H:    r = {{16{h[15]}}, h};
      LD_W:    r = word;
      LD_BU:   r = {24'h0, b};
      LD_HU:   r = {16'h0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the M-stage initiator and the memory responder.
//   req_*  : request fields, held stable by the initiator while stall=1
//   req_ready : responder idle and able to accept
//   rsp_*  : one-cycle completion pulse with load data and error flag
//   stall  : req_valid & ~rsp_valid, to the hazard unit
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_wr_strb;
  logic [2:0]  req_rd_strb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_wr_strb, req_rd_strb, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_wr_strb, req_rd_strb, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/dmem_responder_lane_ctrl.sv
// dmem_lane_ctrl: combinational byte-lane logic for the responder.
//   Inputs : we, wr_strb, rd_strb, addr_lo (addr[1:0]), wdata, rword (RAM word)
//   Outputs: byte_en (write mask), wdata_sh (store data replicated to lanes),
//            misalign, bad_code (reserved strb for the current direction),
//            rdata_ext (selected and extended load result)
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  wr_strb,
  input  logic [2:0]  rd_strb,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic        misalign,
  output logic        bad_code,
  output logic [31:0] rdata_ext
);

  always_comb begin
    byte_en  = '0;
    wdata_sh = '0;
    misalign = 1'b0;
    bad_code = 1'b0;
    if (we) begin
      case (wr_strb)
        SW_BYTE: begin
          byte_en  = 4'b0001 << addr_lo;
          wdata_sh = {4{wdata[7:0]}};
        end
        SW_HALF: begin
          byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_sh = {2{wdata[15:0]}};
          misalign = addr_lo[0];
        end
        SW_WORD: begin
          byte_en  = '1;
          wdata_sh = wdata;
          misalign = |addr_lo;
        end
        default: bad_code = 1'b1;
      endcase
    end else begin
      case (rd_strb)
        LD_B, LD_BU: misalign = 1'b0;
        LD_H, LD_HU: misalign = addr_lo[0];
        LD_W:        misalign = |addr_lo;
        default:     bad_code = 1'b1;
      endcase
    end
  end

  assign rdata_ext = load_extend(rword, addr_lo, rd_strb);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM serving the M-stage load/store port.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset (RAM contents are kept)
//   bus   : dmem_responder_if.slave - request, response and stall
// Stores complete at the accept edge (latency 1); loads respond READ_LAT
// cycles after acceptance. Errors (misalign / reserved code) suppress the
// write and return rsp_err=1 with zero data at the normal latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (READ_LAT > 1) ? 4'(READ_LAT - 2) : '0;

  state_t          state, state_nxt;
  logic [3:0]      count, count_nxt;
  logic [2:0]      lat_rd_strb;
  logic [AW+1:0]   lat_addr;
  logic [31:0]     rsp_rdata_q, rsp_rdata_nxt;
  logic            rsp_err_q, rsp_err_nxt;
  logic            cap_rsp;
  logic            accept;
  logic            mem_we;

  logic [31:0]     mem [DEPTH];

  // Lane logic sees the live request while idle and the latched one while
  // waiting, so a single instance serves both READ_LAT=1 and delayed reads.
  logic            sel_idle;
  logic [2:0]      sel_rd_strb;
  logic [AW+1:0]   sel_addr;
  logic [31:0]     rword;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_sh;
  logic            misalign;
  logic            bad_code;
  logic [31:0]     rdata_ext;
  logic            acc_err;
  logic            unused_addr_hi;

  assign sel_idle    = (state == IDLE);
  assign sel_rd_strb = sel_idle ? bus.req_rd_strb : lat_rd_strb;
  assign sel_addr    = sel_idle ? bus.req_addr[AW+1:0] : lat_addr;
  assign rword       = mem[sel_addr[AW+1:2]];
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  dmem_lane_ctrl u_lane (
    .we        (sel_idle & bus.req_we),
    .wr_strb   (bus.req_wr_strb),
    .rd_strb   (sel_rd_strb),
    .addr_lo   (sel_addr[1:0]),
    .wdata     (bus.req_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .misalign  (misalign),
    .bad_code  (bad_code),
    .rdata_ext (rdata_ext)
  );

  assign acc_err = misalign | bad_code;

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    cap_rsp       = 1'b0;
    rsp_rdata_nxt = '0;
    rsp_err_nxt   = 1'b0;
    accept        = 1'b0;
    mem_we        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (bus.req_we) begin
            mem_we      = ~acc_err;
            cap_rsp     = 1'b1;
            rsp_err_nxt = acc_err;
            state_nxt   = RESP;
          end else if (READ_LAT == 1) begin
            cap_rsp       = 1'b1;
            rsp_err_nxt   = acc_err;
            rsp_rdata_nxt = acc_err ? '0 : rdata_ext;
            state_nxt     = RESP;
          end else begin
            count_nxt = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == '0) begin
          cap_rsp       = 1'b1;
          rsp_err_nxt   = acc_err;
          rsp_rdata_nxt = acc_err ? '0 : rdata_ext;
          state_nxt     = RESP;
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      lat_rd_strb <= '0;
      lat_addr    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (accept) begin
        lat_rd_strb <= bus.req_rd_strb;
        lat_addr    <= bus.req_addr[AW+1:0];
      end
      if (cap_rsp) begin
        rsp_rdata_q <= rsp_rdata_nxt;
        rsp_err_q   <= rsp_err_nxt;
      end
    end
  end

  // No write may land while reset holds the FSM in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[sel_addr[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.stall     = bus.req_valid & ~bus.rsp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned MAIN_LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  logic rst_lat;
  int   n_checks;
  int   n_errors;
  sb_entry_t sb_q[$];

  dmem_responder_if u_if ();

  dmem_responder #(.DEPTH(DEPTH), .READ_LAT(MAIN_LAT)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every response pulse pops one expected entry.
  always @(negedge clk) begin
    if (u_if.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rsp", sb_q.size(), 1);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        chk("sb_rdata", u_if.rsp_rdata, e.rdata);
        chk("sb_err", {31'b0, u_if.rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] ws, input logic [2:0] rs,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat);
    int cyc;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    u_if.req_valid   = 1'b1;
    u_if.req_we      = we;
    u_if.req_wr_strb = ws;
    u_if.req_rd_strb = rs;
    u_if.req_addr    = addr;
    u_if.req_wdata   = wdata;
    #1;
    chk("ready_at_req", {31'b0, u_if.req_ready}, 32'd1);
    chk("stall_at_req", {31'b0, u_if.stall}, 32'd1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      chk("ready_busy", {31'b0, u_if.req_ready}, 32'd0);
      if (u_if.rsp_valid !== 1'b1) chk("stall_wait", {31'b0, u_if.stall}, 32'd1);
    end while (u_if.rsp_valid !== 1'b1 && cyc < 40);
    chk("latency", cyc, exp_lat);
    chk("stall_resp", {31'b0, u_if.stall}, 32'd0);
    @(negedge clk);
    u_if.req_valid = 1'b0;
  endtask

  task automatic st(input logic [1:0] ws, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic exp_err);
    do_req(1'b1, ws, LD_W, addr, wdata, 32'h0, exp_err, 1);
  endtask

  task automatic ld(input logic [2:0] rs, input logic [31:0] addr, input logic [31:0] exp_rdata,
                    input logic exp_err);
    do_req(1'b0, SW_WORD, rs, addr, 32'h0, exp_rdata, exp_err, MAIN_LAT);
  endtask

  // Latency builds: READ_LAT=1 and READ_LAT=4, checked directly.
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned LAT = (g == 0) ? 1 : 4;
    bit done;
    dmem_responder_if lif ();
    dmem_responder #(.DEPTH(16), .READ_LAT(LAT)) u_lat (
      .clk (clk),
      .rst (rst_lat),
      .bus (lif)
    );

    initial begin
      int cyc;
      done            = 1'b0;
      lif.req_valid   = 1'b0;
      lif.req_we      = 1'b0;
      lif.req_wr_strb = SW_WORD;
      lif.req_rd_strb = LD_W;
      lif.req_addr    = '0;
      lif.req_wdata   = '0;
      wait (rst_lat === 1'b1);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        lif.req_valid = 1'b1;
        lif.req_we    = (k == 0);
        lif.req_addr  = 32'h24;
        lif.req_wdata = 32'hA5A5_0F0F;
        #1;
        chk($sformatf("lat%0d_ready_idle", LAT), {31'b0, lif.req_ready}, 32'd1);
        cyc = 0;
        do begin
          @(posedge clk);
          #1;
          cyc++;
          chk($sformatf("lat%0d_ready_busy", LAT), {31'b0, lif.req_ready}, 32'd0);
        end while (lif.rsp_valid !== 1'b1 && cyc < 40);
        chk($sformatf("lat%0d_cycles_%0d", LAT, k), cyc, (k == 0) ? 1 : LAT);
        chk($sformatf("lat%0d_rdata_%0d", LAT, k), lif.rsp_rdata, (k == 0) ? 32'h0 : 32'hA5A5_0F0F);
        chk($sformatf("lat%0d_err_%0d", LAT, k), {31'b0, lif.rsp_err}, 32'd0);
        @(negedge clk);
        lif.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("lat%0d_ready_after", LAT), {31'b0, lif.req_ready}, 32'd1);
      end
      done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    n_checks = 0;
    n_errors = 0;
    rst_n   = 1'b0;
    rst_lat = 1'b0;
    u_if.req_valid   = 1'b0;
    u_if.req_we      = 1'b0;
    u_if.req_wr_strb = SW_WORD;
    u_if.req_rd_strb = LD_W;
    u_if.req_addr    = '0;
    u_if.req_wdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, u_if.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, u_if.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", u_if.rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, u_if.rsp_err}, 32'd0);
    chk("rst_stall", {31'b0, u_if.stall}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    rst_lat = 1'b1;

    st(SW_WORD, 32'h10, 32'hDEAD_BEEF, 1'b0);
    ld(LD_W,  32'h10, 32'hDEAD_BEEF, 1'b0);

    st(SW_BYTE, 32'h13, 32'h1234_5680, 1'b0);
    ld(LD_B,  32'h13, 32'hFFFF_FF80, 1'b0);
    ld(LD_BU, 32'h13, 32'h0000_0080, 1'b0);
    ld(LD_W,  32'h10, 32'h80AD_BEEF, 1'b0);

    st(SW_HALF, 32'h12, 32'h0000_1234, 1'b0);
    ld(LD_H,  32'h12, 32'h0000_1234, 1'b0);
    ld(LD_HU, 32'h12, 32'h0000_1234, 1'b0);
    st(SW_HALF, 32'h11, 32'h0000_1234, 1'b1);
    st(2'b11,   32'h10, 32'hFFFF_FFFF, 1'b1);
    st(SW_WORD, 32'h12, 32'h0000_0000, 1'b1);
    ld(LD_W,  32'h10, 32'h1234_BEEF, 1'b0);
    ld(LD_B,  32'h10, 32'hFFFF_FFEF, 1'b0);
    ld(LD_BU, 32'h11, 32'h0000_00BE, 1'b0);
    ld(LD_H,  32'h10, 32'hFFFF_BEEF, 1'b0);
    ld(LD_HU, 32'h10, 32'h0000_BEEF, 1'b0);
    ld(LD_W,  32'h12, 32'h0000_0000, 1'b1);
    ld(LD_HU, 32'h11, 32'h0000_0000, 1'b1);

    st(SW_WORD, 32'h4, 32'hCAFE_F00D, 1'b0);
    ld(LD_W, 32'h4, 32'hCAFE_F00D, 1'b0);
    ld(LD_W, 32'h4 + 4 * DEPTH, 32'hCAFE_F00D, 1'b0);
    st(SW_WORD, 32'h8 + 3 * 4 * DEPTH, 32'h0000_55AA, 1'b0);
    ld(LD_W, 32'h8, 32'h0000_55AA, 1'b0);
    ld(3'b011, 32'h4, 32'h0000_0000, 1'b1);

    // Reset during WAIT: the load must vanish without a response.
    @(negedge clk);
    u_if.req_valid   = 1'b1;
    u_if.req_we      = 1'b0;
    u_if.req_rd_strb = LD_W;
    u_if.req_addr    = 32'h10;
    @(posedge clk);
    #1;
    chk("wait_ready", {31'b0, u_if.req_ready}, 32'd0);
    chk("wait_rsp_valid", {31'b0, u_if.rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, u_if.req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'b0, u_if.rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    u_if.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'b0, u_if.req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_rsp", {31'b0, u_if.rsp_valid}, 32'd0);
    end
    ld(LD_W, 32'h4, 32'hCAFE_F00D, 1'b0);

    i = 0;
    while (!(g_lat[0].done && g_lat[1].done) && i < 400) begin
      @(posedge clk);
      i++;
    end
    chk("lat_tests_done", {30'b0, g_lat[1].done, g_lat[0].done}, 32'd3);
    repeat (2) @(posedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
